// File: rtl/switch_conditioner.sv
// Four-channel push-button conditioner: 2-FF sync, debounce FSM per switch,
// registered level/press/release pulses and hold-to-repeat pulses.
module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Level,
  output logic [3:0] o_Press,
  output logic [3:0] o_Release,
  output logic [3:0] o_Repeat
);

  localparam int NUM_SW  = 4;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] ST_QUAL_H = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_QUAL_L = 2'd3;

  logic [NUM_SW-1:0] sync_meta, sync_s;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= i_Switch;
      sync_s    <= sync_meta;
    end
  end

  for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
    logic [1:0]       state;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             level_q, press_q, rel_q, rpt_q;
    logic             s;

    assign s = sync_s[n];

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        state     <= ST_LOW;
        db_cnt    <= '0;
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
        rpt_q     <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
        case (state)
          ST_LOW: begin
            if (s) begin
              state  <= ST_QUAL_H;
              db_cnt <= '0;
            end
          end
          ST_QUAL_H: begin
            if (!s) begin
              state <= ST_LOW;
            end else if (db_cnt == DB_LAST) begin
              state     <= ST_HIGH;
              level_q   <= 1'b1;
              press_q   <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          // Repeat counter only advances on held cycles; a dip into QUAL_LOW freezes it.
          ST_HIGH: begin
            if (!s) begin
              state  <= ST_QUAL_L;
              db_cnt <= '0;
            end else if (rpt_cnt == (rpt_first ? RD_LAST : RP_LAST)) begin
              rpt_q     <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          ST_QUAL_L: begin
            if (s) begin
              state <= ST_HIGH;
            end else if (db_cnt == DB_LAST) begin
              state   <= ST_LOW;
              level_q <= 1'b0;
              rel_q   <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= ST_LOW;
        endcase
      end
    end

    assign o_Level[n]   = level_q;
    assign o_Press[n]   = press_q;
    assign o_Release[n] = rel_q;
    assign o_Repeat[n]  = rpt_q;
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_switch_conditioner;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [3:0] i_Switch;
  logic [3:0] o_Level, o_Press, o_Release, o_Repeat;

  int checks   = 0;
  int failures = 0;

  switch_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch),
    .o_Level  (o_Level),
    .o_Press  (o_Press),
    .o_Release(o_Release),
    .o_Repeat (o_Repeat)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
    checks++;
    assert (obs === want)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                      input logic [3:0] rel, input logic [3:0] rpt);
    chk({tag, "_level"},   o_Level,   lvl);
    chk({tag, "_press"},   o_Press,   prs);
    chk({tag, "_release"}, o_Release, rel);
    chk({tag, "_repeat"},  o_Repeat,  rpt);
  endtask

  task automatic expect_n(input string tag, input int n, input logic [3:0] lvl,
                          input logic [3:0] prs, input logic [3:0] rel, input logic [3:0] rpt);
    for (int i = 0; i < n; i++) begin
      tick();
      chk4($sformatf("%s_c%0d", tag, i), lvl, prs, rel, rpt);
    end
  endtask

  initial begin
    logic [3:0] lvl, prs, rel, rpt;

    // Reset state
    i_Reset  = 1'b1;
    i_Switch = 4'b0000;
    tick();
    tick();
    chk4("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    i_Reset = 1'b0;
    expect_n("idle", 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Clean press on switch 1: press visible after the 7th edge following the input change
    i_Switch = 4'b0001;
    expect_n("clean_qual", 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_n("clean_press", 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    expect_n("clean_hold", 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    i_Switch = 4'b0000;
    expect_n("clean_rqual", 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_n("clean_rel", 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    expect_n("clean_after", 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Bounce on switch 2: never stable long enough
    i_Switch = 4'b0010;
    expect_n("bounce_a", 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    i_Switch = 4'b0000;
    expect_n("bounce_b", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    i_Switch = 4'b0010;
    expect_n("bounce_c", 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    i_Switch = 4'b0000;
    expect_n("bounce_d", 8, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Hold switch 3 for 31 input cycles: press at t7, repeats at t17,20,...,32, release at t38
    i_Switch = 4'b0100;
    for (int t = 1; t <= 42; t++) begin
      tick();
      lvl = (t >= 7 && t < 38) ? 4'b0100 : 4'b0000;
      prs = (t == 7) ? 4'b0100 : 4'b0000;
      rel = (t == 38) ? 4'b0100 : 4'b0000;
      rpt = (t >= 17 && t <= 32 && ((t - 17) % 3 == 0)) ? 4'b0100 : 4'b0000;
      chk4($sformatf("hold_t%0d", t), lvl, prs, rel, rpt);
      if (t == 31) i_Switch = 4'b0000;
    end

    // All four switches together
    i_Switch = 4'b1111;
    expect_n("simul_qual", 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_n("simul_press", 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    expect_n("simul_hold", 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    i_Switch = 4'b0000;
    expect_n("simul_rqual", 6, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    expect_n("simul_rel", 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    expect_n("simul_after", 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // One-cycle glitch low while held: two frozen cycles push first repeat from t17 to t19
    i_Switch = 4'b0100;
    for (int t = 1; t <= 35; t++) begin
      tick();
      lvl = (t >= 7 && t < 32) ? 4'b0100 : 4'b0000;
      prs = (t == 7) ? 4'b0100 : 4'b0000;
      rel = (t == 32) ? 4'b0100 : 4'b0000;
      rpt = (t == 19 || t == 22 || t == 25) ? 4'b0100 : 4'b0000;
      chk4($sformatf("glitch_t%0d", t), lvl, prs, rel, rpt);
      if (t == 11) i_Switch = 4'b0000;
      if (t == 12) i_Switch = 4'b0100;
      if (t == 25) i_Switch = 4'b0000;
    end

    // Reset mid-hold: outputs clear with no release, then re-press after the debounce latency
    i_Switch = 4'b0100;
    expect_n("rst_qual", 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_n("rst_press", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    expect_n("rst_held", 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    i_Reset = 1'b1;
    expect_n("rst_edge", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    i_Reset = 1'b0;
    expect_n("rst_requal", 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_n("rst_repress", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    expect_n("rst_rehold", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    i_Switch = 4'b0000;
    expect_n("rst_rqual", 6, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expect_n("rst_rel", 1, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    expect_n("rst_after", 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
